// File: rtl/lsu_mem_bridge_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_bridge_if
//
// Purpose:
//   Bundles every handshake and bus signal of the load/store bridge. It has
//   three groups: the core-facing request/response channel and the read and
//   write ports of the word-wide data RAM.
//
// Parameters:
//   ADDR_W      byte address width on the request and memory sides
//
// Signals:
//   req_valid   request present (core -> bridge)
//   req_ready   bridge can accept a request (high only when idle)
//   req_we      0 = load, 1 = store
//   req_funct3  RV32I load/store funct3
//   req_addr    byte address
//   req_wdata   store data, sub-word taken from the LSBs
//   resp_valid  one-cycle response strobe
//   resp_rdata  extended load result (0 for stores and errors)
//   resp_err    unsupported funct3 or misaligned access
//   mem_r_en    RAM read enable
//   mem_r_addr  word-aligned RAM read address
//   mem_r_data  RAM read data, valid the cycle after mem_r_en
//   mem_w_en    RAM write enable
//   mem_w_addr  word-aligned RAM write address
//   mem_w_data  full word to write
//
// Modports:
//   slave   the bridge's view
//   master  the environment's view (core requester plus RAM model)
// ----------------------------------------------------------------------------
interface lsu_mem_bridge_if #(
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [31:0]       mem_r_data;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [31:0]       mem_w_data;

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output mem_r_en,
        output mem_r_addr,
        input  mem_r_data,
        output mem_w_en,
        output mem_w_addr,
        output mem_w_data
    );

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  mem_r_en,
        input  mem_r_addr,
        output mem_r_data,
        input  mem_w_en,
        input  mem_w_addr,
        input  mem_w_data
    );

endinterface

// File: rtl/lsu_mem_bridge.sv
// ----------------------------------------------------------------------------
// lsu_mem_bridge
//
// Purpose:
//   Load/store unit between the RV32I core's data-memory port and a word-wide
//   data RAM with a 1-cycle registered read. It accepts byte-addressed
//   LB/LH/LW/LBU/LHU/SB/SH/SW requests. It selects the little-endian lane and
//   sign/zero-extends load data. Sub-word stores are done as read-modify-write,
//   so the RAM only ever sees full-word accesses. Each request gets exactly
//   one response.
//
// Ports:
//   clk     clock
//   rst_n   synchronous reset, active-low
//   bus     lsu_mem_bridge_if.slave (request/response channel + RAM ports)
//
// Parameters:
//   ADDR_W  byte address width; must match the connected interface
//
// Optional build macro:
//   LSU_MISALIGN_CHECK_EN  when defined, the following requests are rejected
//                          with resp_err and make no RAM access:
//                          - halfword requests with addr[0]=1;
//                          - word requests with addr[1:0]!=0.
//                          When undefined, the misaligned low address bits
//                          are ignored.
//
// Latency from the accept edge to resp_valid:
//   load 3, SW 2, SB/SH 4, error 1.
// ----------------------------------------------------------------------------
module lsu_mem_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_mem_bridge_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        MERGE,
        WR,
        RESP
    } state_t;

    state_t            state;

    // Request fields latched at accept. All later work uses these copies,
    // so the requester may change its inputs once the request is accepted.
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       w_data_q;

    logic              req_bad_f3;
    logic              req_misaligned;

    // Legal loads are funct3 0,1,2,4,5. Legal stores are 0,1,2.
    always_comb begin
        req_bad_f3 = 1'b0;
        if (bus.req_we) begin
            req_bad_f3 = (bus.req_funct3 > 3'd2);
        end else begin
            req_bad_f3 = (bus.req_funct3 == 3'd3) ||
                         (bus.req_funct3 == 3'd6) ||
                         (bus.req_funct3 == 3'd7);
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1:0] encodes the access size (0 byte, 1 half, 2 word).
    // It is only consulted here for legal funct3 values.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   req_misaligned = bus.req_addr[0];
            2'b10:   req_misaligned = |bus.req_addr[1:0];
            default: req_misaligned = 1'b0;
        endcase
    end
`else
    assign req_misaligned = 1'b0;
`endif

    // Picks the addressed lane out of a RAM word and extends it to 32 bits.
    // For halfwords only addr[1] matters. For words the low bits are ignored.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{lane_b[7]}}, lane_b};
            3'b001:  res = {{16{lane_h[15]}}, lane_h};
            3'b010:  res = word;
            3'b100:  res = {24'h0, lane_b};
            3'b101:  res = {16'h0, lane_h};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // Overlays the store data on the old RAM word for sub-word stores.
    // Full-word stores never reach MERGE. The fallback branch simply
    // returns the store data unchanged.
    function automatic logic [31:0] store_merge(
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic [31:0] word,
        input logic [31:0] wd
    );
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: res[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    // Main control FSM with its datapath registers.
    // rdata_q and err_q change only on the way into RESP. That keeps the
    // response fields stable from one response to the next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'h0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            w_data_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        if (req_bad_f3 || req_misaligned) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end else if (!bus.req_we) begin
                            state <= RD;
                        end else if (bus.req_funct3[1:0] == 2'b10) begin
                            // A full-word store needs no read of the old word.
                            w_data_q <= bus.req_wdata;
                            state    <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= we_q ? MERGE : CAP;
                end
                CAP: begin
                    rdata_q <= load_extract(funct3_q, addr_q[1:0], bus.mem_r_data);
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                MERGE: begin
                    w_data_q <= store_merge(funct3_q[1:0], addr_q[1:0],
                                            bus.mem_r_data, wdata_q);
                    state    <= WR;
                end
                WR: begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register. RAM addresses come
    // from the latched request, with the byte offset dropped.
    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_r_en   = (state == RD);
    assign bus.mem_w_en   = (state == WR);
    assign bus.resp_valid = (state == RESP);
    assign bus.mem_r_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_w_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_w_data = w_data_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
